dmem_responder: RTL and testbench

- Data-memory responder for the LEGv8 pipeline.
- Serves load/store requests issued by the memory stage, which carries the execute-stage ALU result as the address and readData2 as the store data.
- Internal doubleword memory with fixed, parameterised access latency; valid/ready handshake on both request and response channels.
- The memory stage stalls the pipeline while the request is outstanding.

---
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: doubleword data memory for the LEGv8 memory stage.
// One request is outstanding at a time. Each request is answered after a
// fixed LATENCY, with valid/ready handshakes on the request and response
// channels.
// Optional macro DMEM_BACK2BACK_EN: accept the next request on the same
// edge as the current response completes. Without it, the responder spends
// one idle cycle between a completion and the next acceptance.
module dmem_responder #(
    parameter int N       = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic         resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
    localparam logic [N-1:0] LIMIT = N'(DEPTH * 8);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           wr_q;
    logic [N-1:0]   addr_q;
    logic [N-1:0]   wdata_q;
    logic           resp_valid_q;
    logic           resp_err_q;
    logic [N-1:0]   rdata_q;
    logic [N-1:0]   mem_q [DEPTH];

    logic           accept;
    logic           complete;
    logic           commit;
    logic           wr_d;
    logic [N-1:0]   addr_d;
    logic [N-1:0]   wdata_d;
    logic           err_d;
    logic [AW-1:0]  idx_d;
    logic [N-1:0]   rd_d;

`ifdef DMEM_BACK2BACK_EN
    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
`else
    assign req_ready = (state_q == IDLE);
`endif

    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = resp_err_q;

    // Select the request that commits this edge: the captured one when
    // leaving WAIT, or the live inputs when LATENCY=1 commits at acceptance.
    always_comb begin
        accept   = req_valid && req_ready;
        complete = resp_valid_q && resp_ready;
        wr_d     = (state_q == WAIT) ? wr_q    : req_write;
        addr_d   = (state_q == WAIT) ? addr_q  : req_addr;
        wdata_d  = (state_q == WAIT) ? wdata_q : req_wdata;
        err_d    = (addr_d[2:0] != 3'b000) || (addr_d >= LIMIT);
        idx_d    = addr_d[AW+2:3];
        rd_d     = (!wr_d && !err_d) ? mem_q[idx_d] : '0;
        commit   = ((state_q == WAIT) && (cnt_q == CW'(1))) ||
                   ((LATENCY == 1) && accept);
    end

    // Memory array: cleared on reset, written only by an error-free store
    // at its commit point, so a store cut off by reset never lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && wr_d && !err_d) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

    // Control FSM with registered response outputs. An acceptance overrides
    // the RESP->IDLE move so that back-to-back requests chain directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_d;
                        rdata_q      <= rd_d;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (complete) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        rdata_q      <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                if (LATENCY == 1) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_d;
                    rdata_q      <= rd_d;
                end else begin
                    state_q <= WAIT;
                    cnt_q   <= CW'(LATENCY - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (N=64, DEPTH=64, LATENCY=2).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_BACK2BACK_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 3;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.N(64), .DEPTH(64), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a falling edge and return after the accepting rising edge.
    task automatic issue(input logic wr, input logic [63:0] a, input logic [63:0] d);
        int g;
        g = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("accept_in_time", 64'(g < 20), 64'd1);
        @(posedge clk);
    endtask

    // Count falling edges after acceptance until resp_valid is seen.
    task automatic wait_resp(output int lat);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("resp_in_time", 64'(lat < 20), 64'd1);
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic transact(input logic wr, input logic [63:0] a, input logic [63:0] d,
                            output logic [63:0] rd, output logic er, output int lat);
        issue(wr, a, d);
        wait_resp(lat);
        rd = resp_rdata;
        er = resp_err;
        finish_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic [63:0] b_addr [4];
        logic [63:0] b_data [4];
        int          acc_cyc [4];
        int          resp_cyc [4];
        int          n_acc;
        int          n_resp;
        int          cyc;
        logic        acc;
        logic        cmp;

        b_addr[0] = 64'h0;    b_data[0] = 64'h1111_2222_3333_4444;
        b_addr[1] = 64'h8;    b_data[1] = 64'h5555_6666_7777_8888;
        b_addr[2] = 64'h100;  b_data[2] = 64'h9999_AAAA_BBBB_CCCC;
        b_addr[3] = 64'h1F8;  b_data[3] = 64'hDDDD_EEEE_FFFF_0001;

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);

        transact(1'b0, 64'h0, 64'h0, rd, er, lat);
        check("rst_load0_rdata", rd, 64'd0);
        check("rst_load0_err", 64'(er), 64'd0);
        check("rst_load0_lat", 64'(lat), 64'd2);

        // Store then load.
        transact(1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, rd, er, lat);
        check("st10_rdata", rd, 64'd0);
        check("st10_err", 64'(er), 64'd0);
        check("st10_lat", 64'(lat), 64'd2);
        check("st10_done_valid", 64'(resp_valid), 64'd0);
        transact(1'b0, 64'h10, 64'h0, rd, er, lat);
        check("ld10_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);
        check("ld10_err", 64'(er), 64'd0);
        check("ld10_lat", 64'(lat), 64'd2);

        // Highest valid word.
        transact(1'b1, 64'h1F8, 64'hA5A5_0000_5A5A_FFFF, rd, er, lat);
        check("st1f8_err", 64'(er), 64'd0);
        transact(1'b0, 64'h1F8, 64'h0, rd, er, lat);
        check("ld1f8_rdata", rd, 64'hA5A5_0000_5A5A_FFFF);

        // Errors.
        transact(1'b0, 64'h0C, 64'h0, rd, er, lat);
        check("mis_err", 64'(er), 64'd1);
        check("mis_rdata", rd, 64'd0);
        transact(1'b1, 64'h200, 64'h1234, rd, er, lat);
        check("oor_err", 64'(er), 64'd1);
        check("oor_rdata", rd, 64'd0);
        transact(1'b0, 64'h0, 64'h0, rd, er, lat);
        check("oor_nowrite_rdata", rd, 64'd0);
        check("oor_nowrite_err", 64'(er), 64'd0);

        // Response backpressure with a competing request that must be ignored.
        issue(1'b0, 64'h10, 64'h0);
        wait_resp(lat);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h10;
        req_wdata = 64'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_rdata", resp_rdata, 64'hDEAD_BEEF_CAFE_F00D);
            check("bp_err", 64'(resp_err), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        finish_resp();
        transact(1'b0, 64'h10, 64'h0, rd, er, lat);
        check("bp_ignored_rdata", rd, 64'hDEAD_BEEF_CAFE_F00D);

        // Reset one cycle after a store is accepted.
        issue(1'b1, 64'h8, 64'hFF);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_err", 64'(resp_err), 64'd0);
        check("mid_rst_rdata", resp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        transact(1'b0, 64'h8, 64'h0, rd, er, lat);
        check("mid_rst_ld8", rd, 64'd0);
        transact(1'b0, 64'h10, 64'h0, rd, er, lat);
        check("mid_rst_ld10_cleared", rd, 64'd0);

        // Back-to-back loads with resp_ready held high.
        for (int i = 0; i < 4; i++) begin
            transact(1'b1, b_addr[i], b_data[i], rd, er, lat);
        end
        n_acc  = 0;
        n_resp = 0;
        cyc    = 0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = b_addr[0];
        resp_ready = 1'b1;
        while (n_resp < 4 && cyc < 40) begin
            acc = req_valid && req_ready;
            cmp = resp_valid && resp_ready;
            if (cmp) begin
                check("b2b_rdata", resp_rdata, b_data[n_resp]);
                check("b2b_ready_at_done", 64'(req_ready), 64'(STEP == 2));
                resp_cyc[n_resp] = cyc;
                n_resp++;
            end
            if (acc) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (acc) begin
                if (n_acc < 4) req_addr = b_addr[n_acc];
                else           req_valid = 1'b0;
            end
        end
        check("b2b_all_resp", 64'(n_resp), 64'd4);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("b2b_idle_after", 64'(resp_valid), 64'd0);
        if (n_resp == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("b2b_acc_cycle", 64'(acc_cyc[i] - acc_cyc[0]), 64'(i * STEP));
            end
            check("b2b_span", 64'(resp_cyc[3] - acc_cyc[0]), 64'(4 * STEP - (STEP - 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
